// File: rtl/rocc_pkg.sv
// rtl/rocc_pkg.sv - shared types for the RoCC command issuer
// Purpose: instruction field struct, issuer state encoding, register-file size.
// Ports: none (package).
package rocc_pkg;

    localparam int XREG_N = 32;

    // Field order matches the RoCC instruction word, msb first.
    typedef struct packed {
        logic [6:0] funct;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic       xd;
        logic       xs1;
        logic       xs2;
        logic [4:0] rd;
        logic [6:0] opcode;
    } rocc_inst_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // command register empty
        ST_ISSUE = 2'd1,   // command register full, valid held
        ST_FENCE = 2'd2    // draining for a quiesce request
    } issuer_state_e;

endpackage

// File: rtl/rocc_scoreboard.sv
// rtl/rocc_scoreboard.sv - per-register pending-write scoreboard with in-flight counter
// Purpose: tracks which integer registers await an accelerator response, counts
//          in-flight xd commands and flags responses nobody was waiting for.
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   set_en, set_rd        mark rd pending and count one more in-flight command
//   clr_en, clr_rd        response handshake: clear rd, count one fewer
//   sb                    pending bit per register (bit 0 always 0)
//   outstanding           in-flight xd command count
//   err_unexpected_resp   sticky: response with nothing outstanding or rd not pending
module rocc_scoreboard
    import rocc_pkg::*;
#(
    parameter int MAX_OUTS = 4,
    parameter int OUT_W    = $clog2(MAX_OUTS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              set_en,
    input  logic [4:0]        set_rd,
    input  logic              clr_en,
    input  logic [4:0]        clr_rd,
    output logic [XREG_N-1:0] sb,
    output logic [OUT_W-1:0]  outstanding,
    output logic              err_unexpected_resp
);

    logic [XREG_N-1:0] sb_next;
    logic [OUT_W-1:0]  cnt_next;
    logic              dec;
    logic              bad_resp;

    // Clear before set: a new command reusing a register wins over a stale response.
    always_comb begin
        sb_next = sb;
        if (clr_en) begin
            sb_next[clr_rd] = 1'b0;
        end
        if (set_en && set_rd != 5'd0) begin
            sb_next[set_rd] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // Decrement saturates at zero so a spurious response cannot wrap the count.
    assign dec      = clr_en && (outstanding != '0);
    assign bad_resp = clr_en && ((outstanding == '0) || (clr_rd != 5'd0 && !sb[clr_rd]));

    always_comb begin
        cnt_next = outstanding;
        case ({set_en, dec})
            2'b10:   cnt_next = outstanding + OUT_W'(1);
            2'b01:   cnt_next = outstanding - OUT_W'(1);
            default: cnt_next = outstanding;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb                  <= '0;
            outstanding         <= '0;
            err_unexpected_resp <= 1'b0;
        end else begin
            sb          <= sb_next;
            outstanding <= cnt_next;
            if (bad_resp) begin
                err_unexpected_resp <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rocc_cmd_issuer.sv
// rtl/rocc_cmd_issuer.sv - core-side RoCC command initiator with scoreboard and fence
// Purpose: accepts decoded custom instructions, issues them on rocc_cmd through a
//          one-entry registered command slot, stalls on register hazards and the
//          in-flight limit, forwards responses to writeback, and runs a quiesce handshake.
// Ports:
//   clock, reset                       clock, synchronous active-high reset
//   req_*                              decoded instruction + operands, valid/ready
//   rocc_cmd_valid/ready, rocc_cmd_bits_*  registered command to the accelerator
//   rocc_resp_*                        accelerator response (ready = wb_ready)
//   rocc_busy                          accelerator still working
//   wb_valid/ready, wb_rd, wb_data     integer writeback pass-through
//   fence_req, fence_done              level quiesce request, 1-cycle done pulse
//   outstanding, err_unexpected_resp   in-flight xd count, sticky error
module rocc_cmd_issuer
    import rocc_pkg::*;
#(
    parameter  int xLen     = 64,
    parameter  int MAX_OUTS = 4,
    localparam int OUT_W    = $clog2(MAX_OUTS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_funct,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [4:0]       req_rd,
    input  logic             req_xd,
    input  logic             req_xs1,
    input  logic             req_xs2,
    input  logic [6:0]       req_opcode,
    input  logic [xLen-1:0]  req_rs1_data,
    input  logic [xLen-1:0]  req_rs2_data,
    output logic             rocc_cmd_valid,
    input  logic             rocc_cmd_ready,
    output logic [6:0]       rocc_cmd_bits_inst_funct,
    output logic [4:0]       rocc_cmd_bits_inst_rs2,
    output logic [4:0]       rocc_cmd_bits_inst_rs1,
    output logic             rocc_cmd_bits_inst_xd,
    output logic             rocc_cmd_bits_inst_xs1,
    output logic             rocc_cmd_bits_inst_xs2,
    output logic [4:0]       rocc_cmd_bits_inst_rd,
    output logic [6:0]       rocc_cmd_bits_inst_opcode,
    output logic [xLen-1:0]  rocc_cmd_bits_rs1,
    output logic [xLen-1:0]  rocc_cmd_bits_rs2,
    input  logic             rocc_resp_valid,
    output logic             rocc_resp_ready,
    input  logic [4:0]       rocc_resp_bits_rd,
    input  logic [xLen-1:0]  rocc_resp_bits_data,
    input  logic             rocc_busy,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic [xLen-1:0]  wb_data,
    input  logic             fence_req,
    output logic             fence_done,
    output logic [OUT_W-1:0] outstanding,
    output logic             err_unexpected_resp
);

    issuer_state_e     state;
    rocc_inst_t        cmd_inst;
    logic [XREG_N-1:0] sb;
    logic              hazard;
    logic              at_max;
    logic              accept;
    logic              cmd_fire;
    logic              resp_fire;

    // Scoreboard is read from registers only: a response clearing rd this cycle
    // releases a dependent request on the following cycle.
    assign hazard = (req_xs1 && sb[req_rs1]) ||
                    (req_xs2 && sb[req_rs2]) ||
                    (req_xd  && sb[req_rd]);
    assign at_max = (outstanding == OUT_W'(MAX_OUTS));

    // In ISSUE a new request may only replace the held command when it leaves this cycle.
    assign req_ready = !fence_req && (state != ST_FENCE) && !hazard && !(req_xd && at_max) &&
                       ((state == ST_IDLE) || rocc_cmd_ready);

    assign accept    = req_valid && req_ready;
    assign cmd_fire  = rocc_cmd_valid && rocc_cmd_ready;
    assign resp_fire = rocc_resp_valid && wb_ready;

    assign rocc_resp_ready = wb_ready;
    assign wb_valid        = rocc_resp_valid;
    assign wb_rd           = rocc_resp_bits_rd;
    assign wb_data         = rocc_resp_bits_data;

    assign rocc_cmd_bits_inst_funct  = cmd_inst.funct;
    assign rocc_cmd_bits_inst_rs2    = cmd_inst.rs2;
    assign rocc_cmd_bits_inst_rs1    = cmd_inst.rs1;
    assign rocc_cmd_bits_inst_xd     = cmd_inst.xd;
    assign rocc_cmd_bits_inst_xs1    = cmd_inst.xs1;
    assign rocc_cmd_bits_inst_xs2    = cmd_inst.xs2;
    assign rocc_cmd_bits_inst_rd     = cmd_inst.rd;
    assign rocc_cmd_bits_inst_opcode = cmd_inst.opcode;

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= ST_IDLE;
            rocc_cmd_valid    <= 1'b0;
            cmd_inst          <= '0;
            rocc_cmd_bits_rs1 <= '0;
            rocc_cmd_bits_rs2 <= '0;
            fence_done        <= 1'b0;
        end else begin
            fence_done <= 1'b0;
            if (accept) begin
                cmd_inst          <= '{funct: req_funct, rs2: req_rs2, rs1: req_rs1,
                                       xd: req_xd, xs1: req_xs1, xs2: req_xs2,
                                       rd: req_rd, opcode: req_opcode};
                rocc_cmd_bits_rs1 <= req_rs1_data;
                rocc_cmd_bits_rs2 <= req_rs2_data;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state          <= ST_ISSUE;
                        rocc_cmd_valid <= 1'b1;
                    end else if (fence_req) begin
                        state <= ST_FENCE;
                    end
                end
                ST_ISSUE: begin
                    // A pending fence waits for the held command to leave first.
                    if (cmd_fire && !accept) begin
                        rocc_cmd_valid <= 1'b0;
                        state          <= fence_req ? ST_FENCE : ST_IDLE;
                    end
                end
                ST_FENCE: begin
                    if (outstanding == '0 && !rocc_busy) begin
                        fence_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state          <= ST_IDLE;
                    rocc_cmd_valid <= 1'b0;
                end
            endcase
        end
    end

    rocc_scoreboard #(
        .MAX_OUTS (MAX_OUTS),
        .OUT_W    (OUT_W)
    ) u_scoreboard (
        .clock               (clock),
        .reset               (reset),
        .set_en              (accept && req_xd),
        .set_rd              (req_rd),
        .clr_en              (resp_fire),
        .clr_rd              (rocc_resp_bits_rd),
        .sb                  (sb),
        .outstanding         (outstanding),
        .err_unexpected_resp (err_unexpected_resp)
    );

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// tb/tb_rocc_cmd_issuer.sv - self-checking bench for rocc_cmd_issuer
module tb_rocc_cmd_issuer;

    localparam int XLEN     = 64;
    localparam int MAX_OUTS = 4;
    localparam int OUT_W    = 3;

    logic             clock = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [6:0]       req_funct;
    logic [4:0]       req_rs1, req_rs2, req_rd;
    logic             req_xd, req_xs1, req_xs2;
    logic [6:0]       req_opcode;
    logic [XLEN-1:0]  req_rs1_data, req_rs2_data;
    logic             rocc_cmd_valid, rocc_cmd_ready;
    logic [6:0]       cmd_funct, cmd_opcode;
    logic [4:0]       cmd_rs2, cmd_rs1, cmd_rd;
    logic             cmd_xd, cmd_xs1, cmd_xs2;
    logic [XLEN-1:0]  cmd_d1, cmd_d2;
    logic             rocc_resp_valid, rocc_resp_ready;
    logic [4:0]       rocc_resp_bits_rd;
    logic [XLEN-1:0]  rocc_resp_bits_data;
    logic             rocc_busy;
    logic             wb_valid, wb_ready;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             fence_req, fence_done;
    logic [OUT_W-1:0] outstanding;
    logic             err_unexpected_resp;

    always #5 clock = ~clock;

    rocc_cmd_issuer #(.xLen(XLEN), .MAX_OUTS(MAX_OUTS)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct(req_funct),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .req_xd(req_xd), .req_xs1(req_xs1), .req_xs2(req_xs2), .req_opcode(req_opcode),
        .req_rs1_data(req_rs1_data), .req_rs2_data(req_rs2_data),
        .rocc_cmd_valid(rocc_cmd_valid), .rocc_cmd_ready(rocc_cmd_ready),
        .rocc_cmd_bits_inst_funct(cmd_funct), .rocc_cmd_bits_inst_rs2(cmd_rs2),
        .rocc_cmd_bits_inst_rs1(cmd_rs1), .rocc_cmd_bits_inst_xd(cmd_xd),
        .rocc_cmd_bits_inst_xs1(cmd_xs1), .rocc_cmd_bits_inst_xs2(cmd_xs2),
        .rocc_cmd_bits_inst_rd(cmd_rd), .rocc_cmd_bits_inst_opcode(cmd_opcode),
        .rocc_cmd_bits_rs1(cmd_d1), .rocc_cmd_bits_rs2(cmd_d2),
        .rocc_resp_valid(rocc_resp_valid), .rocc_resp_ready(rocc_resp_ready),
        .rocc_resp_bits_rd(rocc_resp_bits_rd), .rocc_resp_bits_data(rocc_resp_bits_data),
        .rocc_busy(rocc_busy), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .fence_req(fence_req), .fence_done(fence_done),
        .outstanding(outstanding), .err_unexpected_resp(err_unexpected_resp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: set of registers awaiting results, in-flight count,
    // the one command waiting at the accelerator, and whether a quiesce is in progress.
    bit          m_sb[32];
    int          m_cnt;
    bit          m_pend, m_fencing, m_err, m_done;
    logic [31:0] m_inst;
    logic [63:0] m_d1, m_d2;
    int          done_pulses;

    task automatic model_reset();
        foreach (m_sb[i]) m_sb[i] = 1'b0;
        m_cnt = 0; m_pend = 0; m_fencing = 0; m_err = 0; m_done = 0;
        m_inst = '0; m_d1 = '0; m_d2 = '0;
    endtask

    // Inputs are set by the caller just after a rising edge; this checks the
    // combinational outputs, advances the model across the edge, then checks state.
    task automatic step();
        bit hz, exp_ready, acc, cfire, rfire;
        #1;
        if (reset) begin
            model_reset();
        end else begin
            hz = (req_xs1 && m_sb[req_rs1]) || (req_xs2 && m_sb[req_rs2]) || (req_xd && m_sb[req_rd]);
            exp_ready = !fence_req && !m_fencing && !hz && !(req_xd && m_cnt == MAX_OUTS) &&
                        (!m_pend || rocc_cmd_ready);
            check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
            check_eq("resp_ready", 64'(rocc_resp_ready), 64'(wb_ready));
            check_eq("wb_valid", 64'(wb_valid), 64'(rocc_resp_valid));
            if (rocc_resp_valid) begin
                check_eq("wb_rd", 64'(wb_rd), 64'(rocc_resp_bits_rd));
                check_eq("wb_data", wb_data, rocc_resp_bits_data);
            end
            acc   = req_valid && exp_ready;
            cfire = m_pend && rocc_cmd_ready;
            rfire = rocc_resp_valid && wb_ready;
            m_done = 0;
            if (m_fencing) begin
                if (m_cnt == 0 && !rocc_busy) begin
                    m_done = 1;
                    m_fencing = 0;
                end
            end else if (fence_req && (!m_pend || cfire)) begin
                m_fencing = 1;
            end
            if (rfire) begin
                if (m_cnt == 0 || (rocc_resp_bits_rd != 0 && !m_sb[rocc_resp_bits_rd])) m_err = 1;
                m_sb[rocc_resp_bits_rd] = 1'b0;
                if (m_cnt > 0) m_cnt--;
            end
            if (acc) begin
                if (req_xd) begin
                    if (req_rd != 0) m_sb[req_rd] = 1'b1;
                    m_cnt++;
                end
                m_pend = 1;
                m_inst = {req_funct, req_rs2, req_rs1, req_xd, req_xs1, req_xs2, req_rd, req_opcode};
                m_d1 = req_rs1_data;
                m_d2 = req_rs2_data;
            end else if (cfire) begin
                m_pend = 0;
            end
        end
        @(posedge clock);
        #1;
        check_eq("cmd_valid", 64'(rocc_cmd_valid), 64'(m_pend));
        check_eq("cmd_inst", 64'({cmd_funct, cmd_rs2, cmd_rs1, cmd_xd, cmd_xs1, cmd_xs2, cmd_rd, cmd_opcode}),
                 64'(m_inst));
        check_eq("cmd_rs1", cmd_d1, m_d1);
        check_eq("cmd_rs2", cmd_d2, m_d2);
        check_eq("outstanding", 64'(outstanding), 64'(m_cnt));
        check_eq("fence_done", 64'(fence_done), 64'(m_done));
        check_eq("err", 64'(err_unexpected_resp), 64'(m_err));
        if (fence_done) done_pulses++;
    endtask

    task automatic quiet();
        req_valid = 0; rocc_cmd_ready = 1; rocc_resp_valid = 0; wb_ready = 1;
        rocc_busy = 0; fence_req = 0; rocc_resp_bits_rd = '0; rocc_resp_bits_data = '0;
    endtask

    task automatic set_req(input bit v, input bit xd, input bit xs1, input bit xs2,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [63:0] d1, input logic [63:0] d2);
        req_valid = v; req_xd = xd; req_xs1 = xs1; req_xs2 = xs2;
        req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_rs1_data = d1; req_rs2_data = d2;
        req_funct = 7'h05; req_opcode = 7'h0B;
    endtask

    task automatic pick_resp_rd(output logic [4:0] rd);
        int start;
        start = int'($urandom_range(0, 31));
        rd = 5'd0;
        for (int k = 0; k < 32; k++) begin
            if (m_sb[(start + k) % 32]) begin
                rd = 5'((start + k) % 32);
                break;
            end
        end
    endtask

    task automatic drain();
        logic [4:0] rd;
        req_valid = 0;
        for (int k = 0; k < 64 && (m_cnt > 0 || m_pend); k++) begin
            if (m_cnt > 0) begin
                pick_resp_rd(rd);
                rocc_resp_valid = 1; rocc_resp_bits_rd = rd;
            end else begin
                rocc_resp_valid = 0;
            end
            step();
        end
        rocc_resp_valid = 0;
        check_eq("drain_empty", 64'(outstanding), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] opcodes [4];
        opcodes[0] = 7'h0B; opcodes[1] = 7'h2B; opcodes[2] = 7'h5B; opcodes[3] = 7'h7B;
        quiet();
        set_req(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0);
        model_reset();

        // Reset state
        reset = 1; step(); step(); reset = 0;
        check_eq("rst_cmd_valid", 64'(rocc_cmd_valid), 64'd0);
        check_eq("rst_outstanding", 64'(outstanding), 64'd0);
        check_eq("rst_err", 64'(err_unexpected_resp), 64'd0);
        check_eq("rst_cmd_rs1", cmd_d1, 64'd0);

        // Single xd command rd=5 rs1=3 rs2=7, valid one cycle after accept
        rocc_cmd_ready = 0;
        set_req(1, 1, 1, 1, 5'd5, 5'd3, 5'd7, 64'h1111, 64'h2222);
        step();
        req_valid = 0;
        check_eq("single_valid", 64'(rocc_cmd_valid), 64'd1);
        check_eq("single_rs1", cmd_d1, 64'h1111);
        check_eq("single_rs2", cmd_d2, 64'h2222);
        check_eq("single_rd", 64'(cmd_rd), 64'd5);
        check_eq("single_outs", 64'(outstanding), 64'd1);
        rocc_cmd_ready = 1;
        step();

        // RAW on rs1=5 until the rd=5 response handshakes
        set_req(1, 0, 1, 0, 5'd0, 5'd5, 5'd0, 64'h33, 64'h44);
        #1 check_eq("raw_stall", 64'(req_ready), 64'd0);
        step(); step();
        rocc_resp_valid = 1; rocc_resp_bits_rd = 5'd5; rocc_resp_bits_data = 64'hA;
        #1 check_eq("raw_wb_rd", 64'(wb_rd), 64'd5);
        check_eq("raw_wb_data", wb_data, 64'hA);
        check_eq("raw_same_cycle", 64'(req_ready), 64'd0);
        step();
        rocc_resp_valid = 0;
        #1 check_eq("raw_release", 64'(req_ready), 64'd1);
        step();
        req_valid = 0;
        step();

        // Backpressure: held command stable, next request waits
        rocc_cmd_ready = 0;
        set_req(1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 64'hBEEF, 64'h1);
        step();
        set_req(1, 0, 0, 0, 5'd0, 5'd1, 5'd2, 64'hCAFE, 64'h2);
        for (int k = 0; k < 4; k++) begin
            #1 check_eq("bp_req_held", 64'(req_ready), 64'd0);
            step();
            check_eq("bp_stable", cmd_d1, 64'hBEEF);
        end
        rocc_cmd_ready = 1;
        step();
        check_eq("bp_next_loaded", cmd_d1, 64'hCAFE);
        req_valid = 0;
        step();

        // In-flight limit
        for (int i = 1; i <= 4; i++) begin
            set_req(1, 1, 0, 0, 5'(i), 5'd0, 5'd0, 64'(i), 64'd0);
            step();
        end
        req_valid = 0;
        step();
        check_eq("max_count", 64'(outstanding), 64'd4);
        set_req(1, 1, 0, 0, 5'd6, 5'd0, 5'd0, 64'h6, 64'd0);
        #1 check_eq("max_xd_stall", 64'(req_ready), 64'd0);
        step();
        set_req(1, 0, 0, 0, 5'd6, 5'd0, 5'd0, 64'h7, 64'd0);
        #1 check_eq("max_nonxd_pass", 64'(req_ready), 64'd1);
        step();
        req_valid = 0;
        rocc_resp_valid = 1; rocc_resp_bits_rd = 5'd1;
        step();
        rocc_resp_valid = 0;
        set_req(1, 1, 0, 0, 5'd6, 5'd0, 5'd0, 64'h8, 64'd0);
        #1 check_eq("max_slot_freed", 64'(req_ready), 64'd1);
        step();
        drain();

        // Fence with two outstanding and accelerator busy
        set_req(1, 1, 0, 0, 5'd10, 5'd0, 5'd0, 64'hA0, 64'd0); step();
        set_req(1, 1, 0, 0, 5'd11, 5'd0, 5'd0, 64'hB0, 64'd0); step();
        req_valid = 0; step();
        rocc_busy = 1; fence_req = 1; done_pulses = 0;
        repeat (3) step();
        rocc_resp_valid = 1; rocc_resp_bits_rd = 5'd10; step();
        rocc_resp_valid = 0; step();
        rocc_resp_valid = 1; rocc_resp_bits_rd = 5'd11; step();
        rocc_resp_valid = 0;
        repeat (2) step();
        check_eq("fence_early", 64'(done_pulses), 64'd0);
        rocc_busy = 0;
        for (int k = 0; k < 8 && done_pulses == 0; k++) step();
        fence_req = 0;
        step();
        check_eq("fence_one_pulse", 64'(done_pulses), 64'd1);
        check_eq("fence_pulse_ends", 64'(fence_done), 64'd0);

        // Unexpected response, sticky until reset, and after reset
        rocc_resp_valid = 1; rocc_resp_bits_rd = 5'd9; rocc_resp_bits_data = 64'h99;
        #1 check_eq("unexp_wb_rd", 64'(wb_rd), 64'd9);
        step();
        rocc_resp_valid = 0;
        check_eq("unexp_err", 64'(err_unexpected_resp), 64'd1);
        step(); step();
        check_eq("unexp_sticky", 64'(err_unexpected_resp), 64'd1);
        reset = 1; step(); reset = 0;
        check_eq("unexp_cleared", 64'(err_unexpected_resp), 64'd0);
        set_req(1, 1, 0, 0, 5'd3, 5'd0, 5'd0, 64'h3, 64'd0); step();
        req_valid = 0; step();
        reset = 1; step(); reset = 0;
        rocc_resp_valid = 1; rocc_resp_bits_rd = 5'd3; step();
        rocc_resp_valid = 0;
        check_eq("resp_after_reset_err", 64'(err_unexpected_resp), 64'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] rd;
            reset = (c % 600 == 0);
            req_valid = ($urandom % 3) != 0;
            req_xd = 1'($urandom); req_xs1 = 1'($urandom); req_xs2 = 1'($urandom);
            req_rd = 5'($urandom % 8); req_rs1 = 5'($urandom % 8); req_rs2 = 5'($urandom % 8);
            req_funct = 7'($urandom); req_opcode = opcodes[$urandom % 4];
            req_rs1_data = {$urandom, $urandom}; req_rs2_data = {$urandom, $urandom};
            rocc_cmd_ready = ($urandom % 4) != 0;
            if (m_cnt > 0 && ($urandom % 3) == 0) begin
                pick_resp_rd(rd);
                rocc_resp_valid = 1; rocc_resp_bits_rd = rd;
            end else if (($urandom % 60) == 0) begin
                rocc_resp_valid = 1; rocc_resp_bits_rd = 5'($urandom);
            end else begin
                rocc_resp_valid = 0;
            end
            rocc_resp_bits_data = {$urandom, $urandom};
            wb_ready = ($urandom % 4) != 0;
            rocc_busy = ($urandom % 4) == 0;
            if (fence_req) begin
                if (m_done) fence_req = 0;
            end else begin
                fence_req = ($urandom % 40) == 0;
            end
            step();
        end

        quiet();
        reset = 1; step(); reset = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
